// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution slice: prediction record, FSM encoding
// and the fall-through instruction size.
package branch_resolve_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic        cond;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_pred_queue.sv
// pred_queue: circular FIFO of in-flight predictions with a synchronous clear
// that wins over any same-cycle push or pop.
module pred_queue
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  pred_entry_t       push_entry_i,
    input  logic              pop_i,
    output pred_entry_t       head_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    pred_entry_t      mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by the
    // pointers and count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: checks resolved branches against queued predictions, raises a
// one-cycle flush on mispredict and feeds the predictor. Optional: BRANCH_STATS_EN.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic        pred_cond,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        pred_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        upd_branch,
    output logic        upd_result,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] q_count;
    pred_entry_t      head;
    pred_entry_t      push_entry;

    br_state_e   state_q, state_d;
    logic        push, pop, empty_res, mispredict;
    logic [31:0] correct_pc;

    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        upd_branch_q, upd_branch_d;
    logic        upd_result_q, upd_result_d;
    logic        err_q, err_d;

    assign push_entry = '{cond: pred_cond, pc: pred_pc, taken: pred_taken, target: pred_target};

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (mispredict),
        .push_i       (push && !mispredict),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (q_count)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pred_ready   = (q_count != CNT_W'(DEPTH)) && (state_q == RUN);
        push         = pred_valid && pred_ready;
        pop          = res_valid && (q_count != '0) && (state_q == RUN);
        empty_res    = res_valid && (q_count == '0) && (state_q == RUN);
        mispredict   = pop && ((head.taken != res_taken) ||
                               (res_taken && (head.target != res_target)));
        correct_pc   = res_taken ? res_target : head.pc + INSTR_BYTES;
        flush_d      = mispredict;
        redirect_d   = mispredict ? correct_pc : redirect_q;
        upd_branch_d = pop && head.cond;
        upd_result_d = pop && head.cond && res_taken;
        err_d        = err_q || empty_res;

        case (state_q)
            RUN:     if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            upd_branch_q <= 1'b0;
            upd_result_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            upd_branch_q <= upd_branch_d;
            upd_result_q <= upd_result_d;
            err_q        <= err_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign upd_branch  = upd_branch_q;
    assign upd_result  = upd_result_q;
    assign err         = err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (pop)        stat_branches_q    <= stat_branches_q + 32'd1;
            if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a reference queue model predicts each
// cycle's registered outputs, which are compared one cycle later.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid, pred_cond, pred_taken;
    logic [31:0] pred_pc, pred_target;
    logic        pred_ready;
    logic        res_valid, res_taken;
    logic [31:0] res_target;
    logic        upd_branch, upd_result, flush, err;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_resolve #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_cond   (pred_cond),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .upd_branch  (upd_branch),
        .upd_result  (upd_result),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .err         (err)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] redirect;
        logic        upd_b;
        logic        upd_r;
        logic        err;
        int          count;
    } exp_t;

    exp_t        sb[$];
    pred_entry_t mq[$];
    logic        flush_m;
    logic [31:0] redirect_m;
    logic        err_m;
    int          stat_b_m, stat_m_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic pred_entry_t mk(input logic c, input logic [31:0] p,
                                       input logic t, input logic [31:0] tg);
        pred_entry_t e;
        e.cond = c; e.pc = p; e.taken = t; e.target = tg;
        return e;
    endfunction

    task automatic clear_inputs();
        pred_valid = 0; pred_cond = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
        res_valid = 0; res_taken = 0; res_target = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        flush_m = 0; redirect_m = '0; err_m = 0;
        stat_b_m = 0; stat_m_m = 0;
    endtask

    // One clock: drive inputs, predict via the model, then compare after the edge.
    task automatic drive_cycle(input logic pv, input pred_entry_t pe,
                               input logic rv, input logic rt, input logic [31:0] rtg);
        exp_t        e;
        pred_entry_t h;
        logic        ready_m, pop_m, mis_m, empty_m;
        pred_valid = pv; pred_cond = pe.cond; pred_pc = pe.pc;
        pred_taken = pe.taken; pred_target = pe.target;
        res_valid = rv; res_taken = rt; res_target = rtg;
        #1;
        ready_m = (mq.size() != DEPTH) && !flush_m;
        check("pred_ready", {31'd0, pred_ready}, {31'd0, ready_m});
        empty_m = (mq.size() == 0);
        pop_m   = rv && !empty_m && !flush_m;
        mis_m   = 0;
        e.upd_b = 0;
        e.upd_r = 0;
        if (pop_m) begin
            h = mq.pop_front();
            mis_m   = (h.taken != rt) || (rt && (h.target != rtg));
            e.upd_b = h.cond;
            e.upd_r = h.cond && rt;
            stat_b_m++;
            if (mis_m) begin
                stat_m_m++;
                redirect_m = rt ? rtg : h.pc + 32'd4;
            end
        end
        if (rv && empty_m && !flush_m) err_m = 1;
        if (mis_m) mq.delete();
        else if (pv && ready_m) mq.push_back(pe);
        flush_m    = mis_m;
        e.flush    = mis_m;
        e.redirect = redirect_m;
        e.err      = err_m;
        e.count    = mq.size();
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("flush",       {31'd0, flush},      {31'd0, e.flush});
        check("redirect_pc", redirect_pc,         e.redirect);
        check("upd_branch",  {31'd0, upd_branch}, {31'd0, e.upd_b});
        check("upd_result",  {31'd0, upd_result}, {31'd0, e.upd_r});
        check("err",         {31'd0, err},        {31'd0, e.err});
        check("count",       32'(dut.q_count),    32'(e.count));
        clear_inputs();
    endtask

    task automatic idle();
        drive_cycle(0, '0, 0, 0, '0);
    endtask

    task automatic push(input pred_entry_t pe);
        drive_cycle(1, pe, 0, 0, '0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtg);
        drive_cycle(0, '0, 1, rt, rtg);
    endtask

    // Resolve the model's head exactly as predicted, optionally with a push.
    task automatic resolve_ok(input logic pv, input pred_entry_t pe);
        drive_cycle(pv, pe, 1, mq[0].taken, mq[0].target);
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        check("rst_flush",    {31'd0, flush},      32'd0);
        check("rst_redirect", redirect_pc,         32'd0);
        check("rst_upd",      {31'd0, upd_branch}, 32'd0);
        check("rst_err",      {31'd0, err},        32'd0);
        check("rst_count",    32'(dut.q_count),    32'd0);
        check("rst_ready",    {31'd0, pred_ready}, 32'd1);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Correct taken prediction.
        push(mk(1, 32'h100, 1, 32'h140));
        resolve(1, 32'h140);
        idle();

        // Direction mispredict with a second entry queued; the flush cycle
        // must refuse a push and ignore a resolve.
        push(mk(1, 32'h200, 1, 32'h180));
        push(mk(1, 32'h210, 0, 32'h0));
        resolve(0, 32'h0);
        drive_cycle(1, mk(1, 32'h220, 1, 32'h260), 1, 1, 32'h260);
        idle();

        // JAL target mispredict: no predictor update.
        push(mk(0, 32'h300, 1, 32'h400));
        resolve(1, 32'h408);
        idle();

        // Fill to DEPTH, refuse an extra push, then pop+push across pointer wrap.
        push(mk(1, 32'h500, 1, 32'h520));
        push(mk(0, 32'h504, 1, 32'h600));
        push(mk(1, 32'h508, 0, 32'h50c));
        push(mk(1, 32'h50c, 1, 32'h540));
        push(mk(1, 32'h510, 1, 32'h700));
        resolve_ok(1, mk(1, 32'h514, 0, 32'h0));
        resolve_ok(1, mk(1, 32'h518, 1, 32'h800));
        resolve_ok(1, mk(0, 32'h51c, 1, 32'h900));
        repeat (4) resolve_ok(0, '0);
        idle();

        // Not-taken mispredict at the top of the address space wraps to 0.
        push(mk(1, 32'hFFFF_FFFC, 1, 32'h1000));
        resolve(0, 32'h0);
        idle();

        // Empty resolve sets sticky err; then reset with 3 entries and a
        // same-cycle mispredict pending.
        resolve(1, 32'h44);
        idle();
        push(mk(1, 32'h600, 1, 32'h640));
        push(mk(1, 32'h604, 1, 32'h680));
        push(mk(0, 32'h608, 1, 32'h700));
        res_valid = 1; res_taken = 0; res_target = '0;
        do_reset();
        clear_inputs();
        idle();

        // Random mix of pushes, correct and wrong resolves.
        for (int i = 0; i < 80; i++) begin
            logic        pv, rv, rt;
            logic [31:0] rtg;
            pred_entry_t pe;
            pv = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 2) == 0);
            pe = mk(1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} << 2,
                    1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} << 4);
            if (mq.size() != 0) begin
                rt  = mq[0].taken;
                rtg = mq[0].target;
                case ($urandom_range(0, 5))
                    0:       rt  = ~rt;
                    1:       rtg = rtg + 32'd8;
                    default: ;
                endcase
            end else begin
                rt  = 1;
                rtg = 32'h0;
                rv  = rv && ($urandom_range(0, 3) == 0);
            end
            drive_cycle(pv, pe, rv, rt, rtg);
        end

        // Five pops, two of them mispredicting.
        do_reset();
        push(mk(1, 32'h700, 1, 32'h740)); resolve(1, 32'h740);
        push(mk(1, 32'h710, 1, 32'h780)); resolve(0, 32'h0);   idle();
        push(mk(0, 32'h720, 1, 32'h7a0)); resolve(1, 32'h7a0);
        push(mk(0, 32'h730, 1, 32'h7c0)); resolve(1, 32'h7c8); idle();
        push(mk(1, 32'h740, 0, 32'h0));   resolve(0, 32'h0);
`ifdef BRANCH_STATS_EN
        check("stat_branches",    stat_branches,    32'd5);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
        check("stat_model_b",     stat_branches,    32'(stat_b_m));
        check("stat_model_m",     stat_mispredicts, 32'(stat_m_m));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter DEPTH, default 4: number of in-flight predictions tracked. Power of two, 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pred_valid  input  1  fetch presents a predicted control-flow instruction.
REQ-005 pred_cond  input  1  1 = conditional branch, 0 = JAL.
REQ-006 pred_pc  input  32  PC of the predicted instruction.
REQ-007 pred_taken  input  1  predicted direction.
REQ-008 pred_target  input  32  predicted taken target.
REQ-009 pred_ready  output  1  queue can accept a push this cycle.
REQ-010 res_valid  input  1  execute resolves the oldest in-flight entry.
REQ-011 res_taken  input  1  actual direction.
REQ-012 res_target  input  32  actual taken target.
REQ-013 upd_branch  output  1  predictor update strobe, for conditional branches only.
REQ-014 upd_result  output  1  actual direction for the predictor history.
REQ-015 flush  output  1  one-cycle pipeline flush pulse.
REQ-016 redirect_pc  output  32  correct fetch PC; valid while flush=1.
REQ-017 err  output  1  sticky flag: resolve received with the queue empty.

Function
REQ-018 Circular FIFO of DEPTH entries {cond, pc, taken, target}; write and read pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-019 pred_ready = (count != DEPTH) && (state == RUN). It has no combinational dependence on res_valid.
REQ-020 A push occurs on pred_valid && pred_ready. A pop occurs on res_valid && count != 0. Pop and push in the same cycle with no mispredict leave count unchanged.
REQ-021 Mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
REQ-022 Correct PC = res_taken ? res_target : head.pc + 32'd4, with modulo 2^32 wrap.
REQ-023 FSM states: RUN and FLUSH.
  - RUN -> FLUSH on a mispredicting pop.
  - FLUSH -> RUN unconditionally after one cycle.
REQ-024 At the mispredict edge:
  - the queue is emptied (count=0, both pointers equal);
  - any same-cycle push is discarded;
  - flush and redirect_pc are registered high and valid for exactly the following cycle.
REQ-025 In FLUSH: pushes are refused and res_valid is ignored.
REQ-026 upd_branch/upd_result are registered, high one cycle after any pop whose head.cond=1, mispredicted or not; upd_result = res_taken. JAL pops produce no update.
REQ-027 res_valid with count=0 in RUN: no pop, no update, err set to 1 until reset.
REQ-028 redirect_pc holds its last value when flush=0.

Reset
REQ-029 On rst:
  - count=0, pointers=0, state=RUN;
  - flush=0, redirect_pc=0, upd_branch=0, upd_result=0, err=0.
  rst overrides any same-cycle push, pop or mispredict.
REQ-030 Reset asserted mid-operation discards all in-flight entries and any pending flush.

Configuration
REQ-031 With BRANCH_STATS_EN defined: adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches counts every pop.
  - stat_mispredicts counts every mispredicting pop.
  - Both reset to 0 and wrap at 2^32.
REQ-032 Without BRANCH_STATS_EN: the ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 The shared package holds: the entry record typedef, the state encoding (RUN/FLUSH), and the instruction-width constant 4. The opcode constants stay in the existing shared opcode definitions.
REQ-034 One sub-module, pred_queue (parameterised FIFO with a synchronous clear), holds the storage. branch_resolve holds the FSM, compare, update and stats logic.

Verification
REQ-035 Correct taken prediction:
  - Stimulus: push {cond=1, pc=0x100, taken=1, target=0x140}; then res_valid, taken=1, target=0x140.
  - Response: flush stays 0; next cycle upd_branch=1, upd_result=1; count returns to 0.
REQ-036 Direction mispredict:
  - Stimulus: push {cond=1, pc=0x200, taken=1, target=0x180}, then a second entry; resolve taken=0.
  - Response: next cycle flush=1, redirect_pc=0x204; count=0; pred_ready=0 for that cycle.
REQ-037 Target mispredict on JAL:
  - Stimulus: push {cond=0, pc=0x300, taken=1, target=0x400}; resolve taken=1, target=0x408.
  - Response: flush=1, redirect_pc=0x408; upd_branch stays 0.
REQ-038 Full queue with DEPTH=4:
  - Stimulus: 4 pushes, then pred_ready=0; a 5th pred_valid is not stored; a pop plus push in the same cycle.
  - Response: count stays 4 and FIFO order is preserved across pointer wrap.
REQ-039 Empty resolve, then reset:
  - Stimulus: res_valid with the queue empty; then rst while holding 3 entries.
  - Response: err=1 and no update pulse on the empty resolve; after rst, count=0, err=0, flush=0.
REQ-040 BRANCH_STATS_EN defined: 5 pops with 2 mispredicts -> stat_branches=5, stat_mispredicts=2.
